// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Load/store unit between execute and the data-memory bus. Takes
//             the ALU address and store data, runs one valid/ready bus
//             transaction, and returns aligned, sign/zero-extended load data
//             for write-back. Raises busy while the access is in flight.
//  Ports    : clk, rstn (sync, active-low)
//             req/we/size/uns/addr/wdata   - request from execute
//             busy/done/err/load_data      - status and result to the core
//             mem_valid/mem_ready/mem_we/mem_addr/mem_wdata/mem_wstrb/
//             mem_rdata                    - data-memory bus
//  Config   : LSU_MISALIGN_CHECK_EN - when defined, misaligned accesses skip
//             the bus and complete with err=1; when undefined, the low
//             address bits are masked to the access size instead.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [DW-1:0]   load_data,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            mem_we_q, mem_we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [2:0]      off_q, off_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [DW-1:0]   load_data_q, load_data_d;

  // Byte offset masked to the access size. For aligned accesses this is just
  // addr[2:0]; otherwise it is the masking used when checking is compiled out.
  logic [2:0] off;
  always_comb begin
    case (size)
      2'b00:   off = addr[2:0];
      2'b01:   off = {addr[2:1], 1'b0};
      2'b10:   off = {addr[2], 2'b00};
      default: off = 3'b000;
    endcase
  end

  logic misalign;
`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (size)
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      2'b11:   misalign = |addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Store lane replication and strobes; loads never write bytes.
  logic [DW-1:0]   lane_wdata;
  logic [DW/8-1:0] lane_wstrb;
  always_comb begin
    case (size)
      2'b00: begin
        lane_wdata = {8{wdata[7:0]}};
        lane_wstrb = 8'h01 << off;
      end
      2'b01: begin
        lane_wdata = {4{wdata[15:0]}};
        lane_wstrb = 8'h03 << off;
      end
      2'b10: begin
        lane_wdata = {2{wdata[31:0]}};
        lane_wstrb = 8'h0F << off;
      end
      default: begin
        lane_wdata = wdata;
        lane_wstrb = 8'hFF;
      end
    endcase
    if (!we) begin
      lane_wstrb = '0;
    end
  end

  // Load extraction from the captured offset/size.
  logic [DW-1:0] rshift;
  logic [DW-1:0] ext;
  assign rshift = mem_rdata >> {off_q, 3'b000};
  always_comb begin
    case (size_q)
      2'b00:   ext = uns_q ? {{(DW-8){1'b0}}, rshift[7:0]}
                           : {{(DW-8){rshift[7]}}, rshift[7:0]};
      2'b01:   ext = uns_q ? {{(DW-16){1'b0}}, rshift[15:0]}
                           : {{(DW-16){rshift[15]}}, rshift[15:0]};
      2'b10:   ext = uns_q ? {{(DW-32){1'b0}}, rshift[31:0]}
                           : {{(DW-32){rshift[31]}}, rshift[31:0]};
      default: ext = rshift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misalign) begin
            state_d     = DONE;
            load_data_d = '0;
          end else begin
            state_d     = BUS;
            mem_we_d    = we;
            size_d      = size;
            uns_d       = uns;
            off_d       = off;
            mem_addr_d  = {addr[AW-1:3], 3'b000};
            mem_wdata_d = lane_wdata;
            mem_wstrb_d = lane_wstrb;
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          state_d     = DONE;
          load_data_d = mem_we_q ? '0 : ext;
        end
      end
      // req still belongs to the completing instruction here, so ignore it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 3'b000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      load_data_q <= load_data_d;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // High exactly in the DONE cycle that follows a rejected misaligned request.
  logic err_q, err_d;
  assign err_d = (state_q == IDLE) && req && misalign;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // busy drops in DONE so the PC advances on the edge that ends DONE.
  assign busy      = ((state_q == IDLE) && req) || (state_q == BUS);
  assign done      = (state_q == DONE);
  assign mem_valid = (state_q == BUS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign load_data = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Self-checking bench for lsu_ctrl: directed cases plus random
//             transactions compared against a byte-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] load_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.DW(64), .AW(64)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .we        (we),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] obs_addr;
  logic [63:0] obs_wdata;
  logic [7:0]  obs_wstrb;
  logic [63:0] obs_load;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_misalign(input logic [1:0] s, input logic [63:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    int nb;
    nb = 1 << s;
    return (int'(a[2:0]) % nb) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete instruction. With hold=1, req stays high into the next
  // instruction's IDLE cycle (back-to-back issue).
  task automatic run_txn(input bit w, input logic [1:0] s, input bit u,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input int delay, input bit hold);
    int          nb;
    int          o;
    bit          mis;
    logic [63:0] e_wd;
    logic [7:0]  e_st;
    logic [63:0] e_ld;
    nb  = 1 << s;
    o   = int'(a[2:0]);
    o   = o - (o % nb);
    mis = model_misalign(s, a);
    for (int i = 0; i < 8; i++) e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    e_st = '0;
    if (w) for (int i = 0; i < 8; i++) if (i >= o && i < o + nb) e_st[i] = 1'b1;
    e_ld = '0;
    if (!w && !mis) begin
      for (int i = 0; i < nb; i++) e_ld[8*i +: 8] = rd[8*(o+i) +: 8];
      if (!u && nb < 8 && e_ld[8*nb-1])
        for (int i = nb; i < 8; i++) e_ld[8*i +: 8] = 8'hFF;
    end

    @(negedge clk);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = wd;
    mem_rdata = rd; mem_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 1);
    chk("idle_valid", mem_valid, 0);
    chk("idle_done", done, 0);

    if (mis) begin
      @(negedge clk); #1;
      chk("mis_done", done, 1);
      chk("mis_err", err, 1);
      chk("mis_load", load_data, 0);
      chk("mis_busy", busy, 0);
      chk("mis_valid", mem_valid, 0);
    end else begin
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk); #1;
        chk("bus_valid", mem_valid, 1);
        chk("bus_busy", busy, 1);
        chk("bus_done", done, 0);
        chk("bus_we", mem_we, w);
        chk("bus_addr", mem_addr, {a[63:3], 3'b000});
        chk("bus_strb", mem_wstrb, e_st);
        if (w) chk("bus_wdata", mem_wdata, e_wd);
        obs_addr  = mem_addr;
        obs_wdata = mem_wdata;
        obs_wstrb = mem_wstrb;
        mem_ready = (k == delay);
      end
      @(negedge clk); #1;
      mem_ready = 1'b0;
      chk("done_done", done, 1);
      chk("done_err", err, 0);
      chk("done_load", load_data, e_ld);
      chk("done_busy", busy, 0);
      chk("done_valid", mem_valid, 0);
    end
    obs_load = load_data;

    if (!hold) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("post_busy", busy, 0);
      chk("post_valid", mem_valid, 0);
      chk("post_done", done, 0);
    end
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_load", load_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;

    // Store byte at an odd offset, bus accepts immediately.
    run_txn(1'b1, 2'b00, 1'b0, 64'h0000_0000_8000_0003, 64'hAB, 64'h0, 0, 1'b0);
    chk("sb_strb", obs_wstrb, 8'h08);
    chk("sb_addr", obs_addr, 64'h0000_0000_8000_0000);
    chk("sb_wdata", obs_wdata, 64'hABAB_ABAB_ABAB_ABAB);

    // Signed and unsigned half loads from the top lane.
    run_txn(1'b0, 2'b01, 1'b0, 64'h0000_0000_1000_0006, 64'h0, 64'h8001_0000_0000_0000, 0, 1'b0);
    chk("lh_load", obs_load, 64'hFFFF_FFFF_FFFF_8001);
    run_txn(1'b0, 2'b01, 1'b1, 64'h0000_0000_1000_0006, 64'h0, 64'h8001_0000_0000_0000, 0, 1'b0);
    chk("lhu_load", obs_load, 64'h0000_0000_0000_8001);

    // Word load with a slow bus.
    run_txn(1'b0, 2'b10, 1'b0, 64'h0000_0000_2000_0004, 64'h0, 64'h8765_4321_0F0E_0D0C, 3, 1'b0);
    chk("lw_load", obs_load, 64'hFFFF_FFFF_8765_4321);

    // Back-to-back load then store with req held through DONE.
    run_txn(1'b0, 2'b11, 1'b0, 64'h0000_0000_3000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1'b1);
    run_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_3000_0002, 64'h1234_5678_9ABC_BEEF, 64'h0, 0, 1'b0);
    chk("b2b_strb", obs_wstrb, 8'h0C);

    // Double at a word-aligned (not double-aligned) address.
    run_txn(1'b0, 2'b11, 1'b0, 64'h0000_0000_4000_0004, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      bit          w_r;
      bit          u_r;
      bit          h_r;
      logic [1:0]  s_r;
      logic [63:0] a_r;
      int          d_r;
      w_r = 1'($urandom_range(0, 1));
      u_r = 1'($urandom_range(0, 1));
      h_r = (t == 299) ? 1'b0 : 1'($urandom_range(0, 1));
      s_r = 2'($urandom_range(0, 3));
      a_r = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a_r[2:0] = a_r[2:0] & ~3'((1 << s_r) - 1);
      d_r = $urandom_range(0, 3);
      run_txn(w_r, s_r, u_r, a_r, {$urandom, $urandom}, {$urandom, $urandom}, d_r, h_r);
    end

    // Reset while the bus is stalled abandons the transaction.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b11; uns = 1'b0; addr = 64'h1000; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rb_valid", mem_valid, 1);
    rstn = 1'b0;
    req  = 1'b0;
    @(negedge clk); #1;
    chk("rb_rst_valid", mem_valid, 0);
    chk("rb_rst_done", done, 0);
    chk("rb_rst_err", err, 0);
    chk("rb_rst_busy", busy, 0);
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rb_after_done", done, 0);
      chk("rb_after_err", err, 0);
      chk("rb_after_valid", mem_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
